macc_sequencer: RTL

// Sequences one Macc filter engine over a 6x6x3 image (3x3x3 kernel, stride 1), producing a 4x4 activation map.
// It generates image-memory read addresses and frow/fcol/fdep indices, and gates the MACC accumulator reset.
// It captures each finished dot product and emits the results in raster order on a valid/ready stream.
// It sits between the image BRAM (1-cycle read latency), the Macc datapath (latency 1) and the downstream activation sink.

---
 rtl/conv_pkg.sv | 26 ++
 rtl/conv_addr_gen.sv | 57 +++++
 rtl/macc_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared geometry and state encoding for the convolution sequencer.
// One Macc engine sweeps a KxKxIMG_D kernel over an IMG_W x IMG_H image.
package conv_pkg;

    localparam int IMG_W  = 6;
    localparam int IMG_H  = 6;
    localparam int IMG_D  = 3;
    localparam int K      = 3;
    localparam int PIX_W  = 18;
    localparam int ACC_W  = 48;
    localparam int ADDR_W = 7;
    localparam int IDX_W  = 2;

    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;
    localparam int TAPS  = K * K * IMG_D;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        OUT,
        DONE
    } state_t;

endpackage

// File: rtl/conv_addr_gen.sv
// Kernel tap counters (fdep innermost, then fcol, then frow) and the
// image-memory address for the current output position.
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int IMG_W_P  = IMG_W,
    parameter int IMG_D_P  = IMG_D,
    parameter int K_P      = K,
    parameter int ADDR_W_P = ADDR_W
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                step,
    input  logic [1:0]          orow,
    input  logic [1:0]          ocol,
    output logic [1:0]          frow,
    output logic [1:0]          fcol,
    output logic [1:0]          fdep,
    output logic                last_tap,
    output logic [ADDR_W_P-1:0] addr
);

    localparam logic [1:0] K_LAST = 2'(K_P - 1);
    localparam logic [1:0] D_LAST = 2'(IMG_D_P - 1);

    logic [ADDR_W_P-1:0] row_a;
    logic [ADDR_W_P-1:0] col_a;

    always_ff @(posedge clk) begin
        if (clear) begin
            frow <= '0;
            fcol <= '0;
            fdep <= '0;
        end else if (step) begin
            if (fdep == D_LAST) begin
                fdep <= '0;
                if (fcol == K_LAST) begin
                    fcol <= '0;
                    frow <= (frow == K_LAST) ? 2'd0 : frow + 2'd1;
                end else begin
                    fcol <= fcol + 2'd1;
                end
            end else begin
                fdep <= fdep + 2'd1;
            end
        end
    end

    assign last_tap = (frow == K_LAST) && (fcol == K_LAST)
                   && (fdep == D_LAST);

    assign row_a = ADDR_W_P'(orow) + ADDR_W_P'(frow);
    assign col_a = ADDR_W_P'(ocol) + ADDR_W_P'(fcol);
    assign addr  = (row_a * ADDR_W_P'(IMG_W_P) + col_a)
                 * ADDR_W_P'(IMG_D_P) + ADDR_W_P'(fdep);

endmodule

// File: rtl/macc_sequencer.sv
// Drives one Macc engine across the image and streams the finished
// activations out in raster order over a valid/ready handshake.
module macc_sequencer
    import conv_pkg::*;
#(
    parameter int IMG_W_P  = IMG_W,
    parameter int IMG_H_P  = IMG_H,
    parameter int IMG_D_P  = IMG_D,
    parameter int K_P      = K,
    parameter int PIX_W_P  = PIX_W,
    parameter int ACC_W_P  = ACC_W,
    parameter int ADDR_W_P = ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                mem_en,
    output logic [ADDR_W_P-1:0] mem_addr,
    input  logic [PIX_W_P-1:0]  mem_rdata,
    output logic                macc_rst,
    output logic [1:0]          frow,
    output logic [1:0]          fcol,
    output logic [1:0]          fdep,
    output logic [PIX_W_P-1:0]  macc_pixel,
    input  logic [ACC_W_P-1:0]  activation,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W_P-1:0]  out_data,
    output logic [1:0]          out_row,
    output logic [1:0]          out_col
);

    localparam logic [1:0] LAST_COL = 2'(IMG_W_P - K_P);
    localparam logic [1:0] LAST_ROW = 2'(IMG_H_P - K_P);

    state_t     state;
    state_t     state_nx;
    logic       drain_cnt;
    logic       mac_v;
    logic       last_tap;
    logic       last_out;
    logic       hs;
    logic [1:0] tap_row;
    logic [1:0] tap_col;
    logic [1:0] tap_dep;

    conv_addr_gen #(
        .IMG_W_P  (IMG_W_P),
        .IMG_D_P  (IMG_D_P),
        .K_P      (K_P),
        .ADDR_W_P (ADDR_W_P)
    ) u_addr (
        .clk      (clk),
        .clear    (rst || (state != RUN)),
        .step     (state == RUN),
        .orow     (out_row),
        .ocol     (out_col),
        .frow     (tap_row),
        .fcol     (tap_col),
        .fdep     (tap_dep),
        .last_tap (last_tap),
        .addr     (mem_addr)
    );

    assign hs       = (state == OUT) && out_ready;
    assign last_out = (out_row == LAST_ROW) && (out_col == LAST_COL);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (start) state_nx = RUN;
            RUN:   if (last_tap) state_nx = DRAIN;
            DRAIN: if (drain_cnt) state_nx = OUT;
            OUT:   if (out_ready) state_nx = last_out ? DONE : RUN;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign mem_en    = (state == RUN);
    assign out_valid = (state == OUT);

    // BRAM data arrives one cycle after mem_en, so indices follow it.
    always_ff @(posedge clk) begin
        if (rst) begin
            mac_v <= 1'b0;
            frow  <= '0;
            fcol  <= '0;
            fdep  <= '0;
        end else begin
            mac_v <= mem_en;
            frow  <= tap_row;
            fcol  <= tap_col;
            fdep  <= tap_dep;
        end
    end

    assign macc_rst   = ~mac_v;
    assign macc_pixel = mac_v ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            drain_cnt <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
        end else begin
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            if ((state == DRAIN) && drain_cnt)
                out_data <= activation;
            if (hs) begin
                if (out_col == LAST_COL) begin
                    out_col <= '0;
                    out_row <= last_out ? 2'd0 : out_row + 2'd1;
                end else begin
                    out_col <= out_col + 2'd1;
                end
            end
        end
    end

endmodule
